// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the four requesters and the round-robin arbiter.
// The arbiter connects through the slave modport; the requester side uses master.
interface rr_arbiter4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       gnt_new;
  logic [1:0] owner_idx;

  modport master (output req, input gnt, gnt_valid, gnt_new, owner_idx);
  modport slave  (input req, output gnt, gnt_valid, gnt_new, owner_idx);
endinterface

// File: rtl/rr_arbiter4.sv
// 4-requester round-robin arbiter with grant hold and hold-timeout pre-emption.
// The grant is registered and is always one-hot or all-zero.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter4_if.slave bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_e;

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_SAT = (MAX_HOLD != 32'd0) ? HOLD_MAX : {HOLD_W{1'b1}};

  // Returns {found, index}: first set bit of mask searching upward from ptr+1, wrapping.
  function automatic logic [2:0] pick(input logic [3:0] mask, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      cand = ptr + 2'(i);
      if (mask[cand]) begin
        res = {1'b1, cand};
      end
    end
    return res;
  endfunction

  function automatic logic [1:0] enc(input logic [3:0] oh);
    logic [1:0] idx;
    case (oh)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  state_e            state_q, state_d;
  logic [3:0]        gnt_q, gnt_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic              gnt_new_q, gnt_new_d;
  logic [1:0]        owner_idx_q, owner_idx_d;
  logic [1:0]        last_ptr_q, last_ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [3:0] others_s;
  logic [3:0] pick_mask_s;
  logic [2:0] pick_s;
  logic       released_s;
  logic       timeout_s;
  logic       take_s;
  logic       drop_s;

  // Next-state logic: release beats timeout, and a handover never inserts an idle cycle.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_ptr_d  = last_ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_new_d   = 1'b0;
    take_s      = 1'b0;
    drop_s      = 1'b0;
    others_s    = bus.req & ~gnt_q;
    released_s  = ((bus.req & gnt_q) == 4'b0000);
    timeout_s   = (MAX_HOLD != 32'd0) && (hold_cnt_q == HOLD_MAX);
    pick_mask_s = (state_q == GRANT) ? others_s : bus.req;
    pick_s      = pick(pick_mask_s, last_ptr_q);

    case (state_q)
      IDLE: begin
        if (pick_s[2]) begin
          take_s = 1'b1;
        end else begin
          drop_s = 1'b1;
        end
      end
      GRANT: begin
        if (released_s || (timeout_s && pick_s[2])) begin
          if (pick_s[2]) begin
            take_s = 1'b1;
          end else begin
            drop_s = 1'b1;
          end
        end else if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
      end
      default: begin
        drop_s = 1'b1;
      end
    endcase

    if (take_s) begin
      state_d    = GRANT;
      gnt_d      = 4'b0001 << pick_s[1:0];
      last_ptr_d = pick_s[1:0];
      hold_cnt_d = HOLD_ONE;
      gnt_new_d  = 1'b1;
    end else if (drop_s) begin
      state_d    = IDLE;
      gnt_d      = 4'b0000;
      hold_cnt_d = '0;
    end else begin
      state_d    = state_q;
    end

    gnt_valid_d = |gnt_d;
    owner_idx_d = enc(gnt_d);
  end

  // State and output registers; the pointer resets to 3 so req[0] wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= 4'b0000;
      gnt_valid_q <= 1'b0;
      gnt_new_q   <= 1'b0;
      owner_idx_q <= 2'd0;
      last_ptr_q  <= 2'd3;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_new_q   <= gnt_new_d;
      owner_idx_q <= owner_idx_d;
      last_ptr_q  <= last_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_new   = gnt_new_q;
  assign bus.owner_idx = owner_idx_q;

endmodule
